// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared types and constants for the coin credit controller:
//                FSM state encoding, coin values in 5-cent units, default
//                price/ceiling and the 4-bit credit type.
//  Revision    : 1.0  initial release
// ============================================================================
package vend_pkg;

    // Controller states; IDLE means zero credit, CREDIT means non-zero credit
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        REFUND   = 2'd3
    } state_t;

    // Credit held as a count of 5-cent units
    typedef logic [3:0] credit_t;

    // Coin values in 5-cent units
    localparam logic [2:0] NICKEL_U  = 3'd1;
    localparam logic [2:0] DIME_U    = 3'd2;
    localparam logic [2:0] QUARTER_U = 3'd5;

    // Default credit ceiling (60c) and item price (45c)
    localparam int unsigned DEF_MAX_UNITS   = 12;
    localparam int unsigned DEF_PRICE_UNITS = 9;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/coin_value_enc.sv
`default_nettype none
// ============================================================================
//  Module      : coin_value_enc
//  Description : Combinational coin encoder. Maps the one-hot coin pulses to
//                a value in 5-cent units and flags simultaneous coins.
//  Revision    : 1.0  initial release
// ============================================================================
module coin_value_enc
    import vend_pkg::*;
(
    input  logic       coin_n,
    input  logic       coin_d,
    input  logic       coin_q,
    output logic [2:0] add_units,
    output logic       multi_coin
);

    // Decode the coin pulses; more than one coin at once is worth nothing
    always_comb begin
        add_units  = 3'd0;
        multi_coin = 1'b0;
        case ({coin_q, coin_d, coin_n})
            3'b000:  add_units = 3'd0;
            3'b001:  add_units = NICKEL_U;
            3'b010:  add_units = DIME_U;
            3'b100:  add_units = QUARTER_U;
            default: multi_coin = 1'b1;
        endcase
    end

endmodule : coin_value_enc
`default_nettype wire

// File: rtl/coin_credit_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : coin_credit_fsm
//  Description : Vending credit controller. Accumulates coin credit in 5-cent
//                units, runs the dispense and refund handshakes and rejects
//                coins that would overflow the ceiling or arrive while busy.
//                All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module coin_credit_fsm
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_UNITS = DEF_PRICE_UNITS,
    parameter int unsigned MAX_UNITS   = DEF_MAX_UNITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_n,
    input  logic       coin_d,
    input  logic       coin_q,
    input  logic       vend_req,
    input  logic       cancel_req,
    output logic [3:0] credit,
    output logic       coin_reject,
    output logic       dispense,
    output logic       refund,
    output logic [3:0] refund_units,
    output logic       busy
);

    // Price and ceiling at the widths they are compared against
    localparam credit_t    c_price_units = credit_t'(PRICE_UNITS);
    localparam logic [4:0] c_max_sum     = 5'(MAX_UNITS);

    state_t     state_q,        state_d;
    credit_t    credit_q,       credit_d;
    logic       coin_reject_q,  coin_reject_d;
    logic       dispense_q,     dispense_d;
    logic       refund_q,       refund_d;
    credit_t    refund_units_q, refund_units_d;
    logic       busy_q,         busy_d;

    logic [2:0] w_add_units;
    logic       w_multi_coin;
    logic       w_any_coin;
    logic [4:0] w_coin_sum;

    coin_value_enc u_coin_value_enc (
        .coin_n     (coin_n),
        .coin_d     (coin_d),
        .coin_q     (coin_q),
        .add_units  (w_add_units),
        .multi_coin (w_multi_coin)
    );

    // One extra bit so an overflowing coin can be seen before it is credited
    assign w_any_coin = coin_n | coin_d | coin_q;
    assign w_coin_sum = {1'b0, credit_q} + {2'b00, w_add_units};

    // Next-state, credit and output pulse decode
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        coin_reject_d  = 1'b0;
        dispense_d     = 1'b0;
        refund_d       = 1'b0;
        refund_units_d = refund_units_q;

        case (state_q)
            IDLE, CREDIT: begin
                // cancel beats vend beats coin; an accepted request bounces any coin
                if (cancel_req && (credit_q != '0)) begin
                    state_d        = REFUND;
                    refund_units_d = credit_q;
                    credit_d       = '0;
                    refund_d       = 1'b1;
                    coin_reject_d  = w_any_coin;
                end else if (vend_req && (credit_q >= c_price_units)) begin
                    state_d        = DISPENSE;
                    credit_d       = credit_q - c_price_units;
                    dispense_d     = 1'b1;
                    coin_reject_d  = w_any_coin;
                end else if (w_any_coin) begin
                    if (w_multi_coin || (w_coin_sum > c_max_sum)) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = w_coin_sum[3:0];
                        state_d  = CREDIT;
                    end
                end
            end

            DISPENSE: begin
                // Remainder stays as credit; requests are ignored while busy
                coin_reject_d = w_any_coin;
                state_d       = (credit_q != '0) ? CREDIT : IDLE;
            end

            REFUND: begin
                coin_reject_d = w_any_coin;
                state_d       = IDLE;
            end

            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase

        busy_d = (state_d == DISPENSE) || (state_d == REFUND);
    end

    // State and registered outputs; reset abandons any handshake in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            coin_reject_q  <= 1'b0;
            dispense_q     <= 1'b0;
            refund_q       <= 1'b0;
            refund_units_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            coin_reject_q  <= coin_reject_d;
            dispense_q     <= dispense_d;
            refund_q       <= refund_d;
            refund_units_q <= refund_units_d;
            busy_q         <= busy_d;
        end
    end

    assign credit       = credit_q;
    assign coin_reject  = coin_reject_q;
    assign dispense     = dispense_q;
    assign refund       = refund_q;
    assign refund_units = refund_units_q;
    assign busy         = busy_q;

endmodule : coin_credit_fsm
`default_nettype wire

// File: tb/tb_coin_credit_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_credit_fsm
//  Description : Self-checking bench for coin_credit_fsm. A behavioural model
//                pushes the expected output word for every driven cycle; each
//                scenario pops it and compares against the DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coin_credit_fsm;

    logic       clk;
    logic       rst;
    logic       coin_n, coin_d, coin_q, vend_req, cancel_req;
    logic [3:0] credit;
    logic       coin_reject, dispense, refund, busy;
    logic [3:0] refund_units;

    int vectors     = 0;
    int miscompares = 0;

    // Expected word: {credit, coin_reject, dispense, refund, refund_units, busy}
    logic [11:0] sb [$];
    logic [11:0] obs;

    // Behavioural model: 0 idle, 1 credit, 2 dispense, 3 refund
    int m_credit, m_st, m_ru;

    // Stimulus encoding {cancel, vend, quarter, dime, nickel}
    localparam logic [4:0] N = 5'b00001;
    localparam logic [4:0] D = 5'b00010;
    localparam logic [4:0] Q = 5'b00100;
    localparam logic [4:0] V = 5'b01000;
    localparam logic [4:0] C = 5'b10000;
    localparam logic [4:0] Z = 5'b00000;

    coin_credit_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .coin_n       (coin_n),
        .coin_d       (coin_d),
        .coin_q       (coin_q),
        .vend_req     (vend_req),
        .cancel_req   (cancel_req),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .dispense     (dispense),
        .refund       (refund),
        .refund_units (refund_units),
        .busy         (busy)
    );

    assign obs = {credit, coin_reject, dispense, refund, refund_units, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset the model and expect an all-zero output word
    task automatic model_reset();
        m_credit = 0;
        m_st     = 0;
        m_ru     = 0;
        sb.push_back(12'h000);
    endtask

    task automatic model_step(input logic [4:0] v);
        int add = (v[0] ? 1 : 0) + (v[1] ? 2 : 0) + (v[2] ? 5 : 0);
        int cnt = int'(v[0]) + int'(v[1]) + int'(v[2]);
        bit rej = 1'b0;
        bit dis = 1'b0;
        bit rf  = 1'b0;
        if (m_st >= 2) begin
            rej  = (cnt > 0);
            m_st = (m_st == 2 && m_credit > 0) ? 1 : 0;
        end else if (v[4] && m_credit > 0) begin
            rf       = 1'b1;
            m_ru     = m_credit;
            m_credit = 0;
            m_st     = 3;
            rej      = (cnt > 0);
        end else if (v[3] && m_credit >= 9) begin
            dis      = 1'b1;
            m_credit = m_credit - 9;
            m_st     = 2;
            rej      = (cnt > 0);
        end else if (cnt > 1) begin
            rej = 1'b1;
        end else if (cnt == 1) begin
            if (m_credit + add <= 12) begin
                m_credit = m_credit + add;
                m_st     = 1;
            end else begin
                rej = 1'b1;
            end
        end
        sb.push_back({4'(m_credit), rej, dis, rf, 4'(m_ru), (m_st >= 2)});
    endtask

    // Apply one cycle of stimulus and record the expected result
    task automatic drive(input logic [4:0] v);
        coin_n     = v[0];
        coin_d     = v[1];
        coin_q     = v[2];
        vend_req   = v[3];
        cancel_req = v[4];
        model_step(v);
        @(posedge clk);
        #1;
        {cancel_req, vend_req, coin_q, coin_d, coin_n} = 5'b0;
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        {cancel_req, vend_req, coin_q, coin_d, coin_n} = 5'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", obs, exp);
        end
        rst = 1'b0;
        drive(Z);
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_idle: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_coin_accept();
        logic [4:0]  s [7] = '{Q, D, N, V, N, V, Z};
        logic [11:0] exp;
        for (int i = 0; i < 7; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL coin_accept[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_overflow();
        logic [4:0]  s [5] = '{Q, Q, Q, Z, D};
        logic [11:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL overflow[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_vend_cancel();
        logic [4:0]  s [4] = '{V, Z, C, Z};
        logic [11:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL vend_cancel[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_multi_coin();
        logic [4:0]  s [9] = '{N | D, Q, D, D, V | Q, Z, C | N, C, Z};
        logic [11:0] exp;
        for (int i = 0; i < 9; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL multi_coin[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_busy_inputs();
        logic [4:0]  s [9] = '{Q, D, D, V, D, Q, C, C, Z};
        logic [11:0] exp;
        for (int i = 0; i < 9; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL busy_inputs[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  s [9] = '{Q, Q, V, V, D, D, Q, V, Z};
        logic [11:0] exp;
        for (int i = 0; i < 9; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_dispense();
        logic [4:0]  s [4] = '{Q, D, D, V};
        logic [11:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            exp = sb.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL mid_dispense_setup[%0d]: got %h want %h", i, obs, exp);
            end
        end
        // Now in DISPENSE with dispense high; reset asynchronously mid-cycle
        rst = 1'b1;
        model_reset();
        #2;
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL async_reset_drop: got %h want %h", obs, exp);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(Z);
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL after_reset_idle: got %h want %h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_coin_accept();
        test_overflow();
        test_vend_cancel();
        test_multi_coin();
        test_busy_inputs();
        test_back_to_back();
        test_reset_mid_dispense();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the sequence above never completes
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_coin_credit_fsm
`default_nettype wire
